mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the MIPS core: a Moore state machine plus an ALU decoder that sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps. It sits beside the datapath inside `top`. It consumes the instruction opcode/funct fields and the ALU zero flag, and drives every mux select and write enable. It replaces the single-cycle main decoder when the core is built multicycle.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag, same cycle
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = memory data
- regdst  out  1  destination select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next state is DECODE.
- DECODE: alusrcb=11, aluop=00, which computes the branch target. Next state depends on op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH. The instruction is a nop and no write enables are asserted.
- MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD if lw, otherwise MEMWR.
- MEMRD: iord=1, then MEMWB. MEMWB: memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10, then ALUWB. ALUWB: regdst=1, regwrite=1, then FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, then ADDIWB. ADDIWB: regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, then FETCH.
- Any signal not listed for a state is 0.
- pcen = pcwrite | (branch & zero). This is the only Mealy term; it is combinational from zero.
- ALU decoder:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - An unlisted funct yields 010. No X is ever driven.

## Timing
- On a rising edge with reset=1, state becomes FETCH.
- While reset=1, pcen, memwrite, irwrite and regwrite are forced to 0, and every select and alucontrol is 0.
- The first FETCH enables are asserted in the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts it at the next edge. No further write enable is asserted.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bne 3 (when built in), unknown opcode 2.
- State transitions depend only on op, which is sampled while in DECODE. The IR is stable after FETCH.
- Outputs are combinational from state, so they are valid in the same cycle as the state; there is no registered output latency.

## Configuration
- MC_BNE_EN defined:
  - Opcode 000101 in DECODE -> BNE state.
  - BNE drives alusrca=1, aluop=01, pcsrc=01, bne=1, then FETCH.
  - pcen = pcwrite | (branch & zero) | (bne & ~zero).
- MC_BNE_EN undefined:
  - No BNE state exists.
  - Opcode 000101 is treated as unknown (nop, 2 cycles).

## Structure
- A shared package `mips_pkg` holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - the funct constants
  - the alucontrol encodings
  - the state enum `mc_state_t`
- One sub-module, `aludec` (funct, aluop -> alucontrol), which is purely combinational.
- The FSM and output decode live in `mc_controller`.

## Test plan
- Reset held 3 cycles -> all enables 0, alucontrol 000. On release, cycle 1 shows irwrite=1, pcen=1, alusrcb=01.
- op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. iord=1 in MEMRD; memtoreg=1 and regwrite=1 in MEMWB.
- op=000000 with funct 100000, 100010, 100100, 100101, 101010 -> alucontrol in EXECUTE is 010, 110, 000, 001, 111 respectively. ALUWB has regdst=1.
- op=000100 in BRANCH -> zero=1 gives pcen=1 and pcsrc=01; zero=0 gives pcen=0. Both cases return to FETCH after 3 cycles total.
- op=000010 (j) -> JUMP has pcen=1, pcsrc=10. op=000101:
  - with MC_BNE_EN, zero=0 gives pcen=1;
  - without MC_BNE_EN, DECODE goes to FETCH with no enables.
- reset asserted while in MEMRD -> the next edge is FETCH, and regwrite is never asserted for that lw.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the multicycle MIPS control path.
//   - opcode / funct field encodings
//   - alucontrol encodings and the internal aluop encoding
//   - mc_state_t, the multicycle controller state enum
// Optional feature macro: MC_BNE_EN adds the BNE state to mc_state_t.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
`ifdef MC_BNE_EN
    , BNE
`endif
  } mc_state_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// aludec: purely combinational ALU decoder.
// Ports:
//   funct      in  6  instruction[5:0]
//   aluop      in  2  00 add, 01 sub, 10 decode funct
//   alucontrol out 3  ALU operation select
// Unlisted aluop/funct combinations fall back to add so no X is driven.
module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM plus ALU decoder for the multicycle MIPS
// datapath (shared memory, single ALU).
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   op, funct            instruction register fields
//   zero                 ALU zero flag (only feeds pcen)
//   pcen, memwrite, irwrite, regwrite   enables
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc   datapath selects
//   alucontrol           ALU operation
// Optional feature macro: MC_BNE_EN adds a BNE state for opcode 000101.
//
// state   | meaning
// FETCH   | load IR, PC <= PC + 4
// DECODE  | compute branch target, dispatch on op
// MEMADR  | ALU computes rs + imm for lw/sw
// MEMRD   | read memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write rt to memory at ALUOut
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | beq compare, take branch when zero
// ADDIEX  | rs + imm
// ADDIWB  | write result to rt
// JUMP    | PC <= jump target
// BNE     | bne compare, take branch when not zero (MC_BNE_EN only)
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  mc_state_t  state, state_next;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic [2:0] alu_dec;
`ifdef MC_BNE_EN
  logic       bne;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_next = BNE;
`else
          OP_BNE:       state_next = FETCH;
`endif
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // Everything stays at its zero default while reset is high, so an
  // instruction interrupted by reset cannot assert another write enable.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
`ifdef MC_BNE_EN
    bne      = 1'b0;
`endif
    if (!reset) begin
      case (state)
        FETCH: begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = 2'b01;
        end
        DECODE: alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: iord = 1'b1;
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB: regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
`ifdef MC_BNE_EN
        BNE: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          bne     = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  aludec u_aludec (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alu_dec)
  );

  // aludec maps aluop 00 to add, so alucontrol needs its own reset gate.
  assign alucontrol = reset ? 3'b000 : alu_dec;

  // Only Mealy term: branch outcome taken straight from the ALU zero flag.
`ifdef MC_BNE_EN
  assign pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
  assign pcen = pcwrite | (branch & zero);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller. Expected control
// words come from a per-instruction model: instruction class and step index
// within the instruction select the active controls.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctl_t;

  ctl_t obs;
  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, pcsrc, alucontrol};

  function automatic bit bne_built();
`ifdef MC_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int cycles_for(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b000101: return bne_built() ? 3 : 2;
      default:   return 2;
    endcase
  endfunction

  // Control word for step k (0 = fetch) of instruction o with flag z.
  function automatic ctl_t expect_step(input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input int k);
    ctl_t e;
    e = '0;
    e.alucontrol = 3'b010;
    if (k == 0) begin
      e.irwrite = 1'b1;
      e.pcen    = 1'b1;
      e.alusrcb = 2'b01;
    end else if (k == 1) begin
      e.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100011, 6'b101011: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
          end else if (o == 6'b101011) begin
            e.iord     = 1'b1;
            e.memwrite = 1'b1;
          end else if (k == 3) begin
            e.iord = 1'b1;
          end else begin
            e.memtoreg = 1'b1;
            e.regwrite = 1'b1;
          end
        end
        6'b000000: begin
          if (k == 2) begin
            e.alusrca    = 1'b1;
            e.alucontrol = alu_for_funct(f);
          end else begin
            e.regdst   = 1'b1;
            e.regwrite = 1'b1;
          end
        end
        6'b001000: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
          end else begin
            e.regwrite = 1'b1;
          end
        end
        6'b000100, 6'b000101: begin
          e.alusrca    = 1'b1;
          e.alucontrol = 3'b110;
          e.pcsrc      = 2'b01;
          e.pcen       = (o == 6'b000100) ? z : ~z;
        end
        6'b000010: begin
          e.pcsrc = 2'b10;
          e.pcen  = 1'b1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it the
  // same way. zsel < 0 randomizes zero every cycle, otherwise holds it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zsel, input string tag);
    int n;
    n = cycles_for(o);
    op = o;
    funct = f;
    for (int k = 0; k < n; k++) begin
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
      @(negedge clk);
      check($sformatf("%s op=%b f=%b step%0d", tag, o, f, k), expect_step(o, f, zero, k));
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_pool [8];
  logic [5:0] funct_pool [5];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                6'b000100, 6'b000010, 6'b000101, 6'b111111};
    funct_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1;
    op    = 6'($urandom);
    funct = 6'($urandom);
    zero  = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      op = 6'($urandom);
      @(negedge clk);
      check($sformatf("reset hold %0d", i), ctl_t'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    run_instr(6'b100011, 6'b000000, -1, "lw");
    run_instr(6'b101011, 6'b000000, -1, "sw");
    for (int i = 0; i < 5; i++) run_instr(6'b000000, funct_pool[i], -1, "rtype");
    run_instr(6'b000000, 6'b111111, -1, "rtype unlisted funct");
    run_instr(6'b001000, 6'b010101, -1, "addi");
    run_instr(6'b000100, 6'b000000, 1, "beq taken");
    run_instr(6'b000100, 6'b000000, 0, "beq not taken");
    run_instr(6'b000010, 6'b000000, -1, "j");
    run_instr(6'b000101, 6'b000000, 0, "bne zero0");
    run_instr(6'b000101, 6'b000000, 1, "bne zero1");
    run_instr(6'b111111, 6'b100000, -1, "unknown op");

    // Reset while a lw sits in MEMRD.
    op = 6'b100011;
    funct = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("lw abort step%0d", k), expect_step(op, funct, zero, k));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("lw abort memrd", expect_step(op, funct, zero, 3));
    reset = 1'b1;
    #1;
    check("reset in memrd", ctl_t'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(6'b100011, 6'b000001, -1, "lw after abort");

    for (int i = 0; i < 150; i++) begin
      logic [5:0] o;
      logic [5:0] f;
      o = op_pool[$urandom_range(0, 7)];
      if (o == 6'b111111) o = 6'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 4)];
      run_instr(o, f, -1, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
